// File: rtl/shift_seq_ctrl_pkg.sv
// shift_seq_pkg: shared state encoding and width helpers for the shift sequencer
package shift_seq_pkg;
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;
    localparam int GAP_W = 8;
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction
endpackage

// File: rtl/shift_seq_ctrl_if.sv
// shift_seq_ctrl_if: request, shift-register and serial-output bundle of the sequencer
interface shift_seq_ctrl_if import shift_seq_pkg::*; #(parameter int WIDTH = 8) ();
    localparam int CNT_W = cnt_w(WIDTH);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_data;
    logic [CNT_W-1:0] req_nbits;
    logic             fill_bit;
    logic             sr_load_en;
    logic             sr_shift_en;
    logic [WIDTH-1:0] sr_data_in;
    logic             sr_serial_in;
    logic             tx_valid;
    logic             tx_ready;
    logic             abort;
    logic             busy;
    logic             done;
    logic             aborted;
    modport master (
        output req_valid, req_data, req_nbits, fill_bit, tx_ready, abort,
        input  req_ready, sr_load_en, sr_shift_en, sr_data_in, sr_serial_in,
               tx_valid, busy, done, aborted
    );
    modport slave (
        input  req_valid, req_data, req_nbits, fill_bit, tx_ready, abort,
        output req_ready, sr_load_en, sr_shift_en, sr_data_in, sr_serial_in,
               tx_valid, busy, done, aborted
    );
endinterface

// File: rtl/shift_seq_ctrl_cnt.sv
// shift_seq_cnt: loadable up/down counter flagging when it equals a terminal value
module shift_seq_cnt #(parameter int W = 4) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         load,
    input  logic         inc,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] tc_val,
    output logic         tc
);
    logic [W-1:0] q;
    // clear beats load beats count
    always_ff @(posedge clk or posedge rst)
        if (rst) q <= '0;
        else if (clr) q <= '0;
        else if (load) q <= load_val;
        else if (inc) q <= q + 1'b1;
        else if (dec) q <= q - 1'b1;
    assign tc = q == tc_val;
endmodule

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: meters parallel words out of an external shift register LSB first
module shift_seq_ctrl import shift_seq_pkg::*; #(
    parameter int WIDTH = 8,
    parameter int GAP   = 0
) (
    input logic clk,
    input logic rst,
    shift_seq_ctrl_if.slave bus
);
    localparam int CNT_W = cnt_w(WIDTH);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(WIDTH);
    state_t state;
    logic [CNT_W-1:0] len;
    logic [CNT_W-1:0] eff_len;
    logic accept, beat, last, kill, bit_tc, gap_tc;
    assign bus.req_ready    = state == S_IDLE && !rst;
    assign bus.tx_valid     = state == S_SHIFT;
    assign bus.busy         = state != S_IDLE;
    assign bus.sr_load_en   = accept;
    assign bus.sr_shift_en  = beat;
    assign bus.sr_data_in   = bus.req_data;
    assign bus.sr_serial_in = bus.fill_bit;
    assign accept  = bus.req_valid && bus.req_ready;
    assign beat    = bus.tx_valid && bus.tx_ready;
    assign last    = beat && bit_tc;
    assign kill    = bus.abort && bus.busy;
    assign eff_len = (bus.req_nbits == '0 || bus.req_nbits > FULL) ? FULL : bus.req_nbits;
    shift_seq_cnt #(.W(CNT_W)) u_bits (
        .clk(clk), .rst(rst), .clr(accept || kill || last), .load(1'b0),
        .inc(beat), .dec(1'b0), .load_val('0), .tc_val(len - CNT_W'(1)), .tc(bit_tc)
    );
    shift_seq_cnt #(.W(GAP_W)) u_gap (
        .clk(clk), .rst(rst), .clr(kill), .load(last && GAP != 0),
        .inc(1'b0), .dec(state == S_GAP), .load_val(GAP_W'(GAP)), .tc_val(GAP_W'(1)), .tc(gap_tc)
    );
    // frame sequencing; abort outranks completion so a final-beat abort reports aborted only
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state       <= S_IDLE;
            len         <= '0;
            bus.done    <= 1'b0;
            bus.aborted <= 1'b0;
        end else begin
            bus.done    <= 1'b0;
            bus.aborted <= 1'b0;
            if (kill) begin
                state       <= S_IDLE;
                bus.aborted <= 1'b1;
            end else if (accept) begin
                state <= S_SHIFT;
                len   <= eff_len;
            end else if (last) begin
                state    <= GAP != 0 ? S_GAP : S_IDLE;
                bus.done <= 1'b1;
            end else if (state == S_GAP && gap_tc) begin
                state <= S_IDLE;
            end
        end
endmodule

// File: tb/tb_shift_seq_ctrl.sv
// tb_shift_seq_ctrl: directed checks of the shift sequencer with a model of the external register
module tb_shift_seq_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_vec = 0;
    int n_bad = 0;
    logic done_seen = 1'b0;
    logic [7:0] sr = 8'h00;
    logic seq_a5 [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic pat_rdy [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic pat_bit [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    always #5 clk = ~clk;

    shift_seq_ctrl_if #(.WIDTH(8)) a ();
    shift_seq_ctrl_if #(.WIDTH(8)) b ();

    shift_seq_ctrl #(.WIDTH(8), .GAP(0)) u_dut0 (.clk(clk), .rst(rst), .bus(a));
    shift_seq_ctrl #(.WIDTH(8), .GAP(4)) u_dut4 (.clk(clk), .rst(rst), .bus(b));

    // external parallel-load / right-shift register driven by the GAP=0 controller
    always @(posedge clk)
        if (a.sr_load_en) sr <= a.sr_data_in;
        else if (a.sr_shift_en) sr <= {a.sr_serial_in, sr[7:1]};

    always @(negedge clk) if (a.done) done_seen = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic [3:0] n);
        a.req_valid = 1'b1;
        a.req_data  = d;
        a.req_nbits = n;
        #1 chk("send_load_en", a.sr_load_en, 1);
        tick;
        a.req_valid = 1'b0;
    endtask

    initial begin
        int shifts, c, g;
        a.req_valid = 0; a.req_data = 0; a.req_nbits = 0; a.fill_bit = 0; a.tx_ready = 0; a.abort = 0;
        b.req_valid = 0; b.req_data = 0; b.req_nbits = 0; b.fill_bit = 0; b.tx_ready = 0; b.abort = 0;
        #1;
        chk("rst_req_ready", a.req_ready, 0);
        chk("rst_busy", a.busy, 0);
        chk("rst_tx_valid", a.tx_valid, 0);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;
        tick;
        chk("idle_req_ready", a.req_ready, 1);
        chk("idle_done", a.done, 0);
        chk("idle_aborted", a.aborted, 0);
        chk("idle_load_en", a.sr_load_en, 0);

        a.tx_ready = 1'b1;
        send(8'hA5, 4'd0);
        for (int i = 0; i < 8; i++) begin
            chk("basic_tx_valid", a.tx_valid, 1);
            chk("basic_bit", sr[0], seq_a5[i]);
            chk("basic_shift_en", a.sr_shift_en, 1);
            chk("basic_done_early", a.done, 0);
            tick;
        end
        chk("basic_done", a.done, 1);
        chk("basic_req_ready", a.req_ready, 1);
        chk("basic_busy", a.busy, 0);
        tick;
        chk("basic_done_pulse", a.done, 0);

        a.tx_ready = 1'b0;
        send(8'h06, 4'd3);
        shifts = 0;
        for (int k = 0; k < 5; k++) begin
            a.tx_ready = pat_rdy[k];
            #1;
            chk("stall_tx_valid", a.tx_valid, 1);
            chk("stall_bit", sr[0], pat_bit[k]);
            shifts += int'(a.sr_shift_en);
            tick;
        end
        chk("stall_done", a.done, 1);
        chk("stall_shifts", shifts, 3);
        chk("stall_req_ready", a.req_ready, 1);

        send(8'h80, 4'd15);
        shifts = 0;
        g = 0;
        while (!a.done && g < 20) begin
            shifts += int'(a.sr_shift_en);
            tick;
            g++;
        end
        chk("clamp_timeout", g < 20, 1);
        chk("clamp_beats", shifts, 8);
        tick;

        b.tx_ready  = 1'b1;
        b.req_valid = 1'b1;
        b.req_data  = 8'hFF;
        b.req_nbits = 4'd2;
        #1 chk("gap_first_accept", b.sr_load_en, 1);
        tick;
        b.req_data = 8'h00;
        c = 1;
        while (!b.sr_load_en && c < 20) begin
            if (c >= 3) chk("gap_busy", b.busy, 1);
            if (c >= 3) chk("gap_tx_valid", b.tx_valid, 0);
            if (c == 3) chk("gap_done", b.done, 1);
            tick;
            c++;
        end
        chk("gap_second_accept", c, 7);
        tick;
        b.req_valid = 1'b0;
        g = 0;
        while (b.busy && g < 20) begin
            tick;
            g++;
        end
        chk("gap_drain", g < 20, 1);

        done_seen = 1'b0;
        send(8'hA5, 4'd0);
        tick;
        tick;
        a.abort = 1'b1;
        tick;
        a.abort = 1'b0;
        chk("abort_busy", a.busy, 0);
        chk("abort_pulse", a.aborted, 1);
        chk("abort_done", a.done, 0);
        chk("abort_req_ready", a.req_ready, 1);
        chk("abort_tx_valid", a.tx_valid, 0);
        tick;
        chk("abort_pulse_end", a.aborted, 0);
        chk("abort_no_done", done_seen, 0);

        done_seen = 1'b0;
        a.fill_bit = 1'b1;
        send(8'h02, 4'd2);
        tick;
        a.abort = 1'b1;
        #1 chk("final_abort_shift", a.sr_shift_en, 1);
        tick;
        a.abort = 1'b0;
        chk("final_abort_pulse", a.aborted, 1);
        chk("final_abort_done", a.done, 0);
        chk("final_abort_sr", sr, 8'hC0);
        tick;
        chk("final_abort_no_done", done_seen, 0);
        a.fill_bit = 1'b0;

        send(8'hA5, 4'd0);
        tick;
        #2 rst = 1'b1;
        #1;
        chk("arst_tx_valid", a.tx_valid, 0);
        chk("arst_busy", a.busy, 0);
        chk("arst_shift_en", a.sr_shift_en, 0);
        chk("arst_req_ready", a.req_ready, 0);
        done_seen = 1'b0;
        @(posedge clk);
        #3 rst = 1'b0;
        #1 chk("arst_release_ready", a.req_ready, 1);
        tick;
        chk("arst_no_done", done_seen, 0);
        chk("arst_no_aborted", a.aborted, 0);
        send(8'h01, 4'd1);
        chk("arst_new_tx_valid", a.tx_valid, 1);
        chk("arst_new_bit", sr[0], 1);
        tick;
        chk("arst_new_done", a.done, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
